md_hazard_ctrl: RTL and testbench
=================================

MD_HAZARD_CTRL -- requirements
Module: md_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (reset==0 at posedge resets).
REQ-005 SHALL have ports D_rs, D_rt  in  5 each  source registers of the instruction in D.
REQ-006 SHALL have ports D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until operand is needed; 3 = operand unused.
REQ-007 SHALL have port D_is_md  in  1  instruction in D reads or writes HI/LO.
REQ-008 SHALL have ports E_WriteRegAddr  in  5, E_T_new  in  2, E_CU_EN_RegWrite  in  1  E-stage producer.
REQ-009 SHALL have ports M_WriteRegAddr  in  5, M_T_new  in  2, M_CU_EN_RegWrite  in  1  M-stage producer.
REQ-010 SHALL have ports E_md_start  in  1 and E_md_is_div  in  1  multiply/divide issue in E; 1 = div, 0 = mult.
REQ-011 SHALL have port ext_freeze  in  1  freezes the whole pipeline.
REQ-012 SHALL have ports HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_EN_EM  out  1 each  stage register enables.
REQ-013 SHALL have port HCU_FLUSH_DE  out  1  D/E register loads a bubble.
REQ-014 SHALL have ports md_busy  out  1, md_done  out  1  HI/LO unit busy; one-cycle completion pulse.
REQ-015 SHALL have ports stall_cnt  out  16 and md_err  out  1  saturating stall counter; sticky start-while-busy flag.

Function
REQ-016 SHALL declare a register hazard on rs when D_rs!=0, D_rs==E_WriteRegAddr, E_CU_EN_RegWrite=1 and D_Tuse_rs<E_T_new; rt uses D_rt/D_Tuse_rt likewise.
REQ-017 SHALL apply the same rule against M_WriteRegAddr/M_T_new/M_CU_EN_RegWrite; E and M hazards are ORed.
REQ-018 SHALL never raise a hazard for an operand whose Tuse is 3.
REQ-019 SHALL declare an md hazard when D_is_md=1 and (md_busy=1 or E_md_start=1).
REQ-020 SHALL set stall = (register hazard or md hazard) and ext_freeze=0; enables and flush are combinational.
REQ-021 SHALL, on stall: HCU_EN_PC=0, HCU_EN_FD=0, HCU_EN_DE=1, HCU_FLUSH_DE=1, HCU_EN_EM=1.
REQ-022 SHALL, on ext_freeze=1: all four enables 0 and HCU_FLUSH_DE=0, regardless of hazards.
REQ-023 SHALL otherwise drive all enables 1 and HCU_FLUSH_DE=0.
REQ-024 SHALL implement a two-state FSM, IDLE and BUSY, with a 4-bit down-counter md_cnt.
REQ-025 SHALL in IDLE accept E_md_start=1 only when ext_freeze=0: load md_cnt with DIV_CYC if E_md_is_div else MULT_CYC, then enter BUSY.
REQ-026 SHALL in BUSY decrement md_cnt every cycle, including under ext_freeze.
REQ-027 SHALL on md_cnt==1 in BUSY return to IDLE and pulse md_done=1 for that single following cycle.
REQ-028 SHALL hold md_busy=1 exactly while in BUSY, so it is high for N consecutive cycles after an accepted N-cycle start.
REQ-029 SHALL ignore E_md_start=1 in BUSY: counter unaffected, md_err set to 1 and held until reset.
REQ-030 SHALL increment stall_cnt by 1 each cycle stall=1 and saturate at 16'hFFFF; ext_freeze cycles are not counted.
REQ-031 SHALL accept a new start in the cycle md_done is high, since the FSM is already IDLE.

Reset
REQ-032 SHALL on reset==0 at posedge enter IDLE with md_cnt=0, md_done=0, md_err=0 and stall_cnt=0, aborting any operation in progress.
REQ-033 SHALL keep combinational enable outputs input-driven during reset; md_busy=0 from the first cycle after reset.

Verification
REQ-034 SHALL test an E-stage load-use hazard: E_WriteRegAddr=8, E_T_new=2, RegWrite=1, D_rs=8, D_Tuse_rs=1 -> EN_PC=0, EN_FD=0, FLUSH_DE=1, and stall_cnt +1.
REQ-035 SHALL test the $0 and unused-operand cases: the same stimulus with D_rs=0, or with D_Tuse_rs=3 -> no stall and all enables 1.
REQ-036 SHALL test a mult sequence: E_md_start=1 with is_div=0 -> md_busy high 5 cycles, md_done pulse on cycle 6, and D_is_md=1 stalls through all busy cycles.
REQ-037 SHALL test a div start followed by reset==0 at cycle 4 -> md_busy=0 and md_done never asserted.
REQ-038 SHALL test a start while busy: a second E_md_start in BUSY -> md_err=1, remaining count unchanged.
REQ-039 SHALL test ext_freeze=1 together with a hazard -> all enables 0, FLUSH_DE=0, stall_cnt unchanged, md_cnt still decrements.

Source files
------------

// File: rtl/md_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline around it:
// decode-stage operand info, E/M producer info, HI/LO issue, and the
// resulting enables, flush and status outputs.
interface md_hazard_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_Tuse_rs;
  logic [1:0]  D_Tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_WriteRegAddr;
  logic [1:0]  E_T_new;
  logic        E_CU_EN_RegWrite;
  logic [4:0]  M_WriteRegAddr;
  logic [1:0]  M_T_new;
  logic        M_CU_EN_RegWrite;
  logic        E_md_start;
  logic        E_md_is_div;
  logic        ext_freeze;
  logic        HCU_EN_PC;
  logic        HCU_EN_FD;
  logic        HCU_EN_DE;
  logic        HCU_EN_EM;
  logic        HCU_FLUSH_DE;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt;
  logic        md_err;

  // Pipeline side: drives stage information, observes control outputs
  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    output E_WriteRegAddr, E_T_new, E_CU_EN_RegWrite,
    output M_WriteRegAddr, M_T_new, M_CU_EN_RegWrite,
    output E_md_start, E_md_is_div, ext_freeze,
    input  HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_EN_EM, HCU_FLUSH_DE,
    input  md_busy, md_done, stall_cnt, md_err
  );

  // Controller side
  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    input  E_WriteRegAddr, E_T_new, E_CU_EN_RegWrite,
    input  M_WriteRegAddr, M_T_new, M_CU_EN_RegWrite,
    input  E_md_start, E_md_is_div, ext_freeze,
    output HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_EN_EM, HCU_FLUSH_DE,
    output md_busy, md_done, stall_cnt, md_err
  );
endinterface

// File: rtl/md_hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew register-hazard detection against
// the E and M producers, HI/LO unit busy tracking with a down-counter FSM,
// stage enables / D-E bubble insertion, and a saturating stall counter.
module md_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic             clk,
  input logic             reset,
  md_hazard_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYC);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

  state_t      r_state;
  logic [3:0]  r_md_cnt;
  logic        r_md_done;
  logic        r_md_err;
  logic [15:0] r_stall_cnt;

  logic w_haz_rs;
  logic w_haz_rt;
  logic w_md_haz;
  logic w_stall;
  logic w_busy;

  // A consumer conflicts with a producer when it needs the value earlier
  // than the producer can forward it; $0 and unused operands never conflict.
  function automatic logic reg_haz(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] dst, input logic [1:0] tnew,
                                   input logic we);
    return (src != 5'd0) && (tuse != 2'd3) && we && (src == dst) && (tuse < tnew);
  endfunction

  assign w_busy = (r_state == S_BUSY);

  // Hazard detection and stall decision
  always_comb begin
    w_haz_rs = reg_haz(bus.D_rs, bus.D_Tuse_rs, bus.E_WriteRegAddr, bus.E_T_new, bus.E_CU_EN_RegWrite)
             | reg_haz(bus.D_rs, bus.D_Tuse_rs, bus.M_WriteRegAddr, bus.M_T_new, bus.M_CU_EN_RegWrite);
    w_haz_rt = reg_haz(bus.D_rt, bus.D_Tuse_rt, bus.E_WriteRegAddr, bus.E_T_new, bus.E_CU_EN_RegWrite)
             | reg_haz(bus.D_rt, bus.D_Tuse_rt, bus.M_WriteRegAddr, bus.M_T_new, bus.M_CU_EN_RegWrite);
    w_md_haz = bus.D_is_md & (w_busy | bus.E_md_start);
    w_stall  = (w_haz_rs | w_haz_rt | w_md_haz) & ~bus.ext_freeze;
  end

  // Stage enables: freeze holds everything, stall holds F/D and bubbles D/E
  always_comb begin
    bus.HCU_EN_PC    = 1'b1;
    bus.HCU_EN_FD    = 1'b1;
    bus.HCU_EN_DE    = 1'b1;
    bus.HCU_EN_EM    = 1'b1;
    bus.HCU_FLUSH_DE = 1'b0;
    if (bus.ext_freeze) begin
      bus.HCU_EN_PC = 1'b0;
      bus.HCU_EN_FD = 1'b0;
      bus.HCU_EN_DE = 1'b0;
      bus.HCU_EN_EM = 1'b0;
    end else if (w_stall) begin
      bus.HCU_EN_PC    = 1'b0;
      bus.HCU_EN_FD    = 1'b0;
      bus.HCU_FLUSH_DE = 1'b1;
    end
  end

  // HI/LO unit FSM; the countdown keeps running under freeze so the unit
  // finishes on schedule, but new starts are only taken when not frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_md_cnt  <= 4'd0;
      r_md_done <= 1'b0;
      r_md_err  <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.E_md_start && !bus.ext_freeze) begin
            r_md_cnt <= bus.E_md_is_div ? DIV_N : MULT_N;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_md_cnt <= r_md_cnt - 4'd1;
          if (bus.E_md_start) r_md_err <= 1'b1;
          if (r_md_cnt == 4'd1) begin
            r_state   <= S_IDLE;
            r_md_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of hazard-stall cycles (freeze cycles excluded)
  always_ff @(posedge clk) begin
    if (!reset)
      r_stall_cnt <= 16'd0;
    else if (w_stall && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign bus.md_busy   = w_busy;
  assign bus.md_done   = r_md_done;
  assign bus.md_err    = r_md_err;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: the stimulus process drives one
// cycle of inputs and queues the hand-derived expected outputs; the monitor
// pops one entry per cycle on the falling edge and compares.
module tb_md_hazard_ctrl;

  localparam int NORM  = 0;
  localparam int STALL = 1;
  localparam int FRZ   = 2;

  typedef struct {
    string       nm;
    logic [4:0]  en;     // {PC, FD, DE, EM, FLUSH_DE}
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  logic clk;
  logic reset;
  md_hazard_ctrl_if bus ();

  md_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_sc   = 16'd0;
  logic        stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are meaningful every cycle, one queued entry per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp({e.nm, ".en"}, int'({bus.HCU_EN_PC, bus.HCU_EN_FD, bus.HCU_EN_DE,
                                 bus.HCU_EN_EM, bus.HCU_FLUSH_DE}), int'(e.en));
        cmp({e.nm, ".busy"},  int'(bus.md_busy),   int'(e.busy));
        cmp({e.nm, ".done"},  int'(bus.md_done),   int'(e.done));
        cmp({e.nm, ".err"},   int'(bus.md_err),    int'(e.err));
        cmp({e.nm, ".stall"}, int'(bus.stall_cnt), int'(e.sc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int mode, input logic busy,
                     input logic done, input logic err);
    exp_t e;
    e.nm   = nm;
    e.en   = (mode == STALL) ? 5'b00111 : (mode == FRZ) ? 5'b00000 : 5'b11110;
    e.busy = busy;
    e.done = done;
    e.err  = err;
    e.sc   = exp_sc;
    q.push_back(e);
    if (mode == STALL) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic idle_in();
    bus.D_rs = 5'd0;            bus.D_rt = 5'd0;
    bus.D_Tuse_rs = 2'd3;       bus.D_Tuse_rt = 2'd3;
    bus.D_is_md = 1'b0;
    bus.E_WriteRegAddr = 5'd0;  bus.E_T_new = 2'd0;  bus.E_CU_EN_RegWrite = 1'b0;
    bus.M_WriteRegAddr = 5'd0;  bus.M_T_new = 2'd0;  bus.M_CU_EN_RegWrite = 1'b0;
    bus.E_md_start = 1'b0;      bus.E_md_is_div = 1'b0;
    bus.ext_freeze = 1'b0;
  endtask

  task automatic e_loaduse();
    bus.E_WriteRegAddr = 5'd8; bus.E_T_new = 2'd2; bus.E_CU_EN_RegWrite = 1'b1;
    bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd1;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    tick();
    chk("reset", NORM, 0, 0, 0);
    tick();
    reset = 1'b1;

    // Register hazards
    e_loaduse();
    chk("e_loaduse", STALL, 0, 0, 0); tick();
    bus.D_rs = 5'd0;
    chk("rs_zero", NORM, 0, 0, 0); tick();
    bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd3;
    chk("rs_unused", NORM, 0, 0, 0); tick();
    idle_in();
    bus.M_WriteRegAddr = 5'd5; bus.M_T_new = 2'd1; bus.M_CU_EN_RegWrite = 1'b1;
    bus.D_rt = 5'd5; bus.D_Tuse_rt = 2'd0;
    chk("m_rt_haz", STALL, 0, 0, 0); tick();
    bus.D_Tuse_rt = 2'd1;
    chk("m_tuse_eq", NORM, 0, 0, 0); tick();
    bus.D_Tuse_rt = 2'd0; bus.M_CU_EN_RegWrite = 1'b0;
    chk("m_nowrite", NORM, 0, 0, 0); tick();

    // Multiply: 5 busy cycles with D_is_md stalling, then done pulse
    idle_in();
    bus.E_md_start = 1'b1;
    chk("mult_issue", NORM, 0, 0, 0); tick();
    bus.E_md_start = 1'b0; bus.D_is_md = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mult_busy%0d", i + 1), STALL, 1, 0, 0); tick();
    end
    // Done cycle: FSM is idle, so a div start is accepted here
    bus.D_is_md = 1'b0; bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
    chk("mult_done", NORM, 0, 1, 0); tick();

    // Divide aborted by reset in its fourth busy cycle
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("div_busy%0d", i + 1), NORM, 1, 0, 0); tick();
    end
    reset = 1'b0;
    chk("div_rst", NORM, 1, 0, 0); tick();
    exp_sc = 16'd0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("post_rst%0d", i), NORM, 0, 0, 0); tick();
    end

    // Start while busy: flags error, countdown unchanged
    bus.E_md_start = 1'b1;
    chk("err_issue", NORM, 0, 0, 0); tick();
    bus.E_md_start = 1'b0;
    chk("err_b1", NORM, 1, 0, 0); tick();
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
    chk("err_b2", NORM, 1, 0, 0); tick();
    idle_in();
    chk("err_b3", NORM, 1, 0, 1); tick();
    chk("err_b4", NORM, 1, 0, 1); tick();
    chk("err_b5", NORM, 1, 0, 1); tick();
    chk("err_done", NORM, 0, 1, 1); tick();
    chk("err_idle", NORM, 0, 0, 1); tick();

    // Freeze with hazards: all enables low, no stall count, counter still runs
    bus.E_md_start = 1'b1;
    chk("frz_issue", NORM, 0, 0, 1); tick();
    bus.E_md_start = 1'b0;
    chk("frz_b1", NORM, 1, 0, 1); tick();
    e_loaduse(); bus.D_is_md = 1'b1; bus.ext_freeze = 1'b1;
    chk("frz_b2", FRZ, 1, 0, 1); tick();
    chk("frz_b3", FRZ, 1, 0, 1); tick();
    chk("frz_b4", FRZ, 1, 0, 1); tick();
    bus.ext_freeze = 1'b0;
    chk("frz_b5", STALL, 1, 0, 1); tick();
    chk("frz_done", STALL, 0, 1, 1); tick();

    // Start under freeze while idle is not accepted
    idle_in();
    bus.E_md_start = 1'b1; bus.ext_freeze = 1'b1;
    chk("frz_start", FRZ, 0, 0, 1); tick();
    idle_in();
    chk("frz_noacc", NORM, 0, 0, 1); tick();

    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    repeat (3) @(negedge clk);
    cmp("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
